uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the peripheral I/O path.
- Character width is set at elaboration.
- Baud divisor, parity mode and stop-bit count are set at run time.
- A valid/ready handshake replaces the level-triggered run input.
- Sits between the CPU-side TX register/FIFO and the serial pin.
- Single-edge design: all state updates on posedge clk.

Parameters:
DATA_WIDTH, 8, character bits per frame; legal range 5..9, LSB first.
DIV_WIDTH, 13, width of the run-time clocks-per-bit divisor.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
clks_per_bit  input  DIV_WIDTH  clock cycles per serial bit; values 0 and 1 are treated as 2.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none (reserved).
stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
tx_data  input  DATA_WIDTH  character to send.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  block can accept a character.
tx_busy  output  1  frame in progress.
tx_done  output  1  one-cycle pulse at frame end.
txd  output  1  serial line, idle high.

Behaviour:
- Reset values while rst is high and in the following cycle: txd=1, tx_ready=0 while rst is high, tx_busy=0, tx_done=0, state IDLE, all counters 0.
- All outputs are registered except tx_ready. tx_ready = (state==IDLE) && !rst.
- Accept: tx_valid && tx_ready at a posedge. That same edge latches:
  - tx_data into a shift register;
  - clks_per_bit (clamped), parity_mode and stop_bits into config registers.
- Input changes after the accept edge do not affect the frame in flight.
- State machine is IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: txd=1; on accept, go to START.
  - START: txd=0 for exactly N cycles, where N is the latched divisor.
  - DATA: DATA_WIDTH bits, LSB first, each held N cycles. A bit counter runs 0..DATA_WIDTH-1.
  - PARITY: entered only if parity_mode is 01 or 10. Holds N cycles. Even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: txd=1 for N cycles (stop_bits=0) or 2N cycles (stop_bits=1), then go to IDLE.
- Latency: txd falls on the first clock edge after the accept edge.
- Frame length is exactly N*(1+DATA_WIDTH+P+S) cycles, with P in {0,1} and S in {1,2}.
- Baud counter:
  - Counts 0..N-1 and wraps to 0.
  - A bit boundary occurs at count N-1.
  - Cleared on accept and on reset.
- tx_busy is 1 from the cycle after accept until the last stop cycle, inclusive.
- tx_done is high for exactly one cycle: the first IDLE cycle after STOP.
- Back-to-back: tx_ready is already 1 in the tx_done cycle. A character accepted then starts its START bit on the next edge, so the line idles for exactly one cycle between frames.
- Reset mid-frame: the frame is aborted. txd=1 on the next edge, no tx_done pulse, and the shift register contents are discarded.
- tx_valid is ignored when tx_ready is 0; the block never drops an accepted character.
- Divisor width rule: a clamped value of 2 gives the minimum 2 cycles per bit. The all-ones divisor gives 2^DIV_WIDTH-1 cycles; the counter has no overflow.

Decomposition:
- Package uart_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP (3-bit enum);
  - parity constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - DIV_WIDTH default.
- Sub-module uart_baud_tick (DIV_WIDTH parameter) provides the divisor counter with clear/enable. It emits a one-cycle tick at count N-1 and is reusable by the future RX block.

Test Plan:
- 8N1, N=4, tx_data=0xA5, 1 stop, parity 00 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); tx_done pulses on cycle 41 after accept.
- N=3, DATA_WIDTH=8, tx_data=0x07, parity 01 (even), stop_bits=1 -> parity bit 1 and two stop bits; frame lasts 3*12=36 cycles. Same data with parity 10 -> parity bit 0.
- Back-to-back: hold tx_valid high with 0x55 then 0xAA, N=2 -> exactly one idle-high cycle between frames; tx_ready is high only in the IDLE/tx_done cycles; both characters are received intact.
- Config change mid-frame: switch clks_per_bit from 4 to 8 and parity from 00 to 01 during DATA -> the current frame keeps N=4 and no parity; the next frame uses N=8 with parity.
- Reset at bit 3 of DATA -> txd=1 the following cycle, no tx_done, tx_ready=1 after rst drops; the next frame is sent correctly.
- clks_per_bit=0 and clks_per_bit=1 -> each bit lasts 2 cycles; a 9-bit DATA_WIDTH instance sends 0x1FF with 9 data bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM state
// encoding, parity mode codes and elaboration defaults.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DIV_WIDTH_DEF  = 13;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // True when the mode code asks for a parity bit; 11 is reserved and
    // behaves like "none".
    function automatic logic parity_on(input logic [1:0] mode);
        logic on_s;
        case (mode)
            PAR_NONE: on_s = 1'b0;
            PAR_EVEN: on_s = 1'b1;
            PAR_ODD:  on_s = 1'b1;
            default:  on_s = 1'b0;
        endcase
        return on_s;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Character handshake between the CPU-side TX register/FIFO (master)
// and the transmitter (slave).
interface uart_tx_cfg_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Clocks-per-bit divisor counter. Counts 0..div-1 while enabled and
// flags the last count of each bit period; shared with the future RX.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_r;
    logic                 wrap_s;

    // Last count of the bit period; div is always >= 2 here.
    always_comb begin
        wrap_s = (cnt_r == (div - DIV_WIDTH'(1)));
    end

    assign tick = en && wrap_s;

    // Divisor counter: cleared on reset or frame start, wraps at div-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {DIV_WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {DIV_WIDTH{1'b0}};
        end else if (en) begin
            if (wrap_s) begin
                cnt_r <= {DIV_WIDTH{1'b0}};
            end else begin
                cnt_r <= cnt_r + DIV_WIDTH'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: elaboration-time character width,
// run-time divisor, parity and stop bits, valid/ready character input.
// The FSM runs one cycle ahead of the registered txd pin, so the line
// falls on the edge after the accept edge while busy/done track the FSM.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] clks_per_bit,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    uart_tx_cfg_if.slave         bus,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd
);

    localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    // Parity bit for a character: even = XOR of data, odd = inverse.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic [1:0]            mode);
        logic p_s;
        case (mode)
            PAR_EVEN: p_s = ^d;
            PAR_ODD:  p_s = ~(^d);
            default:  p_s = 1'b0;
        endcase
        return p_s;
    endfunction

    uart_state_e           state_r;
    uart_state_e           state_s;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [DIV_WIDTH-1:0]  div_r;
    logic [DIV_WIDTH-1:0]  div_clamped_s;
    logic                  par_en_r;
    logic                  par_bit_r;
    logic                  stop2_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [BW-1:0]         bit_cnt_s;
    logic                  txd_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  baud_en_s;
    logic                  tick_s;
    logic                  txd_r;
    logic                  busy_r;
    logic                  done_r;

    // Handshake: ready only in IDLE and never while reset is held.
    always_comb begin
        ready_s       = (state_r == IDLE) && !rst;
        accept_s      = bus.tx_valid && ready_s;
        baud_en_s     = (state_r != IDLE);
        div_clamped_s = (clks_per_bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : clks_per_bit;
    end

    assign bus.tx_ready = ready_s;

    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept_s),
        .en   (baud_en_s),
        .div  (div_r),
        .tick (tick_s)
    );

    // Next-state, bit counter and line level for the current state.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        txd_s     = 1'b1;
        case (state_r)
            IDLE: begin
                txd_s     = 1'b1;
                bit_cnt_s = {BW{1'b0}};
                if (accept_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                txd_s = 1'b0;
                if (tick_s) begin
                    state_s   = DATA;
                    bit_cnt_s = {BW{1'b0}};
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                txd_s = shreg_r[0];
                if (tick_s) begin
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_s = {BW{1'b0}};
                        state_s   = par_en_r ? PARITY : STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                        state_s   = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                txd_s = par_bit_r;
                if (tick_s) begin
                    state_s   = STOP;
                    bit_cnt_s = {BW{1'b0}};
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                txd_s = 1'b1;
                if (tick_s) begin
                    if (stop2_r && (bit_cnt_r == {BW{1'b0}})) begin
                        bit_cnt_s = BW'(1);
                        state_s   = STOP;
                    end else begin
                        bit_cnt_s = {BW{1'b0}};
                        state_s   = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s   = IDLE;
                bit_cnt_s = {BW{1'b0}};
                txd_s     = 1'b1;
            end
        endcase
    end

    // State and bit counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bit_cnt_r <= {BW{1'b0}};
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
        end
    end

    // Frame snapshot on accept; data shifts out LSB first at bit ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r   <= {DATA_WIDTH{1'b0}};
            div_r     <= {DIV_WIDTH{1'b0}};
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            stop2_r   <= 1'b0;
        end else if (accept_s) begin
            shreg_r   <= bus.tx_data;
            div_r     <= div_clamped_s;
            par_en_r  <= parity_on(parity_mode);
            par_bit_r <= calc_parity(bus.tx_data, parity_mode);
            stop2_r   <= stop_bits;
        end else if ((state_r == DATA) && tick_s) begin
            shreg_r <= {1'b0, shreg_r[DATA_WIDTH-1:1]};
        end
    end

    // Registered outputs: line follows the FSM by one cycle, busy/done
    // are derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_r  <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            txd_r  <= txd_s;
            busy_r <= (state_s != IDLE);
            done_r <= (state_r == STOP) && (state_s == IDLE);
        end
    end

    assign txd     = txd_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: an 8-bit and a 9-bit instance,
// compared cycle by cycle against a frame model built from the UART
// framing rules (start, data LSB first, optional parity, stop bits).
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] clks_per_bit;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        tx_busy, tx_done, txd;

    logic [12:0] cpb9;
    logic [1:0]  mode9;
    logic        stop9;
    logic        busy9, done9, txd9;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;
    bit line_q[$];

    uart_tx_cfg_if #(.DATA_WIDTH(8)) bus ();
    uart_tx_cfg_if #(.DATA_WIDTH(9)) bus9 ();

    uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(13)) dut (
        .clk          (clk),
        .rst          (rst),
        .clks_per_bit (clks_per_bit),
        .parity_mode  (parity_mode),
        .stop_bits    (stop_bits),
        .bus          (bus),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .txd          (txd)
    );

    uart_tx_cfg #(.DATA_WIDTH(9), .DIV_WIDTH(13)) dut9 (
        .clk          (clk),
        .rst          (rst),
        .clks_per_bit (cpb9),
        .parity_mode  (mode9),
        .stop_bits    (stop9),
        .bus          (bus9),
        .tx_busy      (busy9),
        .tx_done      (done9),
        .txd          (txd9)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Vectors are {txd, tx_busy, tx_done, tx_ready}.
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Line level per bit period of one frame.
    function automatic int build_line(input logic [8:0] d, input int w,
                                      input logic [1:0] mode, input logic stop2);
        int ones = 0;
        line_q.delete();
        line_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            line_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (mode == 2'b01) line_q.push_back((ones % 2) != 0);
        else if (mode == 2'b10) line_q.push_back((ones % 2) == 0);
        line_q.push_back(1'b1);
        if (stop2) line_q.push_back(1'b1);
        return line_q.size();
    endfunction

    // Expected outputs k cycles after the accept edge for a frame of f cycles.
    function automatic logic [3:0] exp_vec(input int k, input int n, input int f);
        logic line_s;
        line_s = (k == 0) ? 1'b1 : line_q[(k - 1) / n];
        return {line_s, (k < f), (k == f), (k == f)};
    endfunction

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check($sformatf("idle_f%0d_%0d", frame_no, i), {txd, tx_busy, tx_done, bus.tx_ready}, 4'b1001);
        end
    endtask

    // Send one character on the 8-bit instance; entered and left at a negedge
    // (left in the tx_done cycle, or after releasing an injected reset).
    task automatic send_frame(input logic [7:0] d, input logic [12:0] cpb, input logic [1:0] mode,
                              input logic stop2, input bit keep_valid, input int abort_at);
        int n, f, waited;
        n = (int'(cpb) < 2) ? 2 : int'(cpb);
        f = n * build_line({1'b0, d}, 8, mode, stop2);
        bus.tx_data  = d;
        clks_per_bit = cpb;
        parity_mode  = mode;
        stop_bits    = stop2;
        bus.tx_valid = 1'b1;
        waited = 0;
        while (!bus.tx_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.tx_ready) begin
            check("accept_timeout", {3'b000, bus.tx_ready}, 4'b0001);
            bus.tx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        for (int k = 0; k <= f; k++) begin
            if (k == 0 && !keep_valid) bus.tx_valid = 1'b0;
            if (k == n + 1) begin
                bus.tx_data  = 8'($urandom);
                clks_per_bit = 13'($urandom_range(0, 20));
                parity_mode  = 2'($urandom);
                stop_bits    = 1'($urandom);
            end
            check($sformatf("f%0d_k%0d", frame_no, k), {txd, tx_busy, tx_done, bus.tx_ready}, exp_vec(k, n, f));
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort_rst", {txd, tx_busy, tx_done, bus.tx_ready}, 4'b1000);
                rst = 1'b0;
                @(negedge clk);
                check("abort_rel", {txd, tx_busy, tx_done, bus.tx_ready}, 4'b1001);
                frame_no++;
                return;
            end
            if (k < f) @(negedge clk);
        end
        frame_no++;
    endtask

    // Send one character on the 9-bit instance, then one idle cycle.
    task automatic send9(input logic [8:0] d, input logic [12:0] cpb, input logic [1:0] mode, input logic stop2);
        int n, f, waited;
        n = (int'(cpb) < 2) ? 2 : int'(cpb);
        f = n * build_line(d, 9, mode, stop2);
        bus9.tx_data  = d;
        cpb9          = cpb;
        mode9         = mode;
        stop9         = stop2;
        bus9.tx_valid = 1'b1;
        waited = 0;
        while (!bus9.tx_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus9.tx_ready) begin
            check("accept9_timeout", {3'b000, bus9.tx_ready}, 4'b0001);
            bus9.tx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus9.tx_valid = 1'b0;
        for (int k = 0; k <= f; k++) begin
            if (k == 1) bus9.tx_data = 9'($urandom);
            check($sformatf("w9_f%0d_k%0d", frame_no, k), {txd9, busy9, done9, bus9.tx_ready}, exp_vec(k, n, f));
            if (k < f) @(negedge clk);
        end
        @(negedge clk);
        check($sformatf("w9_idle_f%0d", frame_no), {txd9, busy9, done9, bus9.tx_ready}, 4'b1001);
        frame_no++;
    endtask

    initial begin
        logic [7:0]  d;
        logic [12:0] cpb;
        logic [1:0]  mode;
        logic        stop2;
        bit          keep;

        rst           = 1'b1;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        clks_per_bit  = 13'd4;
        parity_mode   = 2'b00;
        stop_bits     = 1'b0;
        bus9.tx_valid = 1'b0;
        bus9.tx_data  = 9'h000;
        cpb9          = 13'd2;
        mode9         = 2'b00;
        stop9         = 1'b0;

        @(negedge clk);
        check("reset8", {txd, tx_busy, tx_done, bus.tx_ready}, 4'b1000);
        check("reset9", {txd9, busy9, done9, bus9.tx_ready}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset8", {txd, tx_busy, tx_done, bus.tx_ready}, 4'b1001);
        check("post_reset9", {txd9, busy9, done9, bus9.tx_ready}, 4'b1001);

        // 8N1, N=4, 0xA5.
        send_frame(8'hA5, 13'd4, 2'b00, 1'b0, 1'b0, -1);
        idle(2);
        // Even then odd parity with two stop bits, N=3.
        send_frame(8'h07, 13'd3, 2'b01, 1'b1, 1'b0, -1);
        idle(1);
        send_frame(8'h07, 13'd3, 2'b10, 1'b1, 1'b0, -1);
        idle(1);
        // Back-to-back with tx_valid held high, N=2.
        send_frame(8'h55, 13'd2, 2'b00, 1'b0, 1'b1, -1);
        send_frame(8'hAA, 13'd2, 2'b00, 1'b0, 1'b0, -1);
        idle(2);
        // Config change mid-frame, then a frame with the new config.
        send_frame(8'hC3, 13'd4, 2'b00, 1'b0, 1'b0, -1);
        idle(1);
        send_frame(8'h3C, 13'd8, 2'b01, 1'b0, 1'b0, -1);
        idle(1);
        // Divisor clamp.
        send_frame(8'h81, 13'd0, 2'b00, 1'b0, 1'b0, -1);
        idle(1);
        send_frame(8'h81, 13'd1, 2'b11, 1'b1, 1'b0, -1);
        idle(1);
        // Reset during data bit 3 (bit 3 of 0x37 is 0), then a clean frame.
        send_frame(8'h37, 13'd4, 2'b00, 1'b0, 1'b0, 4 * 4 + 2);
        idle(6);
        send_frame(8'h96, 13'd3, 2'b10, 1'b0, 1'b0, -1);
        idle(1);
        // Randomized frames, some back-to-back.
        for (int r = 0; r < 12; r++) begin
            d     = 8'($urandom);
            cpb   = 13'($urandom_range(0, 5));
            mode  = 2'($urandom);
            stop2 = 1'($urandom);
            keep  = (r < 11) && ($urandom_range(0, 1) == 1);
            send_frame(d, cpb, mode, stop2, keep, -1);
            if (!keep) idle($urandom_range(1, 3));
        end
        // 9-bit instance.
        send9(9'h1FF, 13'd1, 2'b00, 1'b0);
        send9(9'h1FF, 13'd0, 2'b10, 1'b1);
        send9(9'h10A, 13'd3, 2'b01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
